// File: rtl/des_f_pipeline.sv
// Two-stage pipelined DES round function f(R, K) with valid/ready handshakes.
// Stage A registers E(R) ^ K; stage B registers P(S(xa)).

module des_f_sbox #(
  parameter logic [255:0] TABLE = '0
) (
  input  logic [5:0] sin,
  output logic [3:0] sout
);
  // Row is {b1,b6} and column is b2..b5; entry 0 sits in the top nibble of TABLE.
  logic [5:0] idx;

  assign idx  = {sin[5], sin[0], sin[4:1]};
  assign sout = TABLE[{~idx, 2'b11} -: 4];
endmodule

module des_f_pipeline #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_r,
  input  logic [47:0]      in_k,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_f,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic             va_q, va_d;
  logic [47:0]      xa_q, xa_d;
  logic [TAG_W-1:0] ta_q, ta_d;
  logic             vb_q, vb_d;
  logic [31:0]      fb_q, fb_d;
  logic [TAG_W-1:0] tb_q, tb_d;

  logic             adv_a;
  logic             adv_b;
  logic [47:0]      e_r;
  logic [31:0]      s_out;
  logic [31:0]      p_out;

  // Bit 31 of R is DES bit 1, so DES bit i lives at in_r[32-i].
  assign e_r = {in_r[0], in_r[31:27], in_r[28:23], in_r[24:19], in_r[20:15],
                in_r[16:11], in_r[12:7], in_r[8:3], in_r[4:0], in_r[31]};

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    des_f_sbox #(
      .TABLE (SBOX_TAB[g])
    ) u_sbox (
      .sin  (xa_q[47-6*g -: 6]),
      .sout (s_out[31-4*g -: 4])
    );
  end

  assign p_out = {s_out[16], s_out[25], s_out[12], s_out[11],
                  s_out[3],  s_out[20], s_out[4],  s_out[15],
                  s_out[31], s_out[17], s_out[9],  s_out[6],
                  s_out[27], s_out[14], s_out[1],  s_out[22],
                  s_out[30], s_out[24], s_out[8],  s_out[18],
                  s_out[0],  s_out[5],  s_out[29], s_out[23],
                  s_out[13], s_out[19], s_out[2],  s_out[26],
                  s_out[10], s_out[21], s_out[28], s_out[7]};

  assign adv_b    = !vb_q || out_ready;
  assign adv_a    = !va_q || adv_b;
  assign in_ready = adv_a;

  assign out_valid = vb_q;
  assign out_f     = fb_q;
  assign out_tag   = tb_q;

  always_comb begin
    va_d = va_q;
    xa_d = xa_q;
    ta_d = ta_q;
    vb_d = vb_q;
    fb_d = fb_q;
    tb_d = tb_q;
    if (adv_a) begin
      va_d = in_valid;
      if (in_valid) begin
        xa_d = e_r ^ in_k;
        ta_d = in_tag;
      end
    end
    if (adv_b) begin
      vb_d = va_q;
      if (va_q) begin
        fb_d = p_out;
        tb_d = ta_q;
      end
    end
    // Flush only kills the valid bits; stale data is harmless once invalid.
    if (flush) begin
      va_d = 1'b0;
      vb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q <= 1'b0;
      xa_q <= '0;
      ta_q <= '0;
      vb_q <= 1'b0;
      fb_q <= '0;
      tb_q <= '0;
    end else begin
      va_q <= va_d;
      xa_q <= xa_d;
      ta_q <= ta_d;
      vb_q <= vb_d;
      fb_q <= fb_d;
      tb_q <= tb_d;
    end
  end

endmodule

// File: tb/tb_des_f_pipeline.sv
// Scoreboard bench for des_f_pipeline: directed vectors plus a table-driven
// DES f model; a negedge monitor pops expected results as outputs transfer.

module tb_des_f_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_r;
  logic [47:0] in_k;
  logic [3:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  des_f_pipeline #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_k      (in_k),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [31:0] f;
    logic [3:0]  tag;
  } exp_t;

  exp_t sbQ[$];
  int   popCycles[$];
  int   cycleCnt = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,   8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,   16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,   24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32, 1};

  localparam int P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,      19, 13, 30, 6, 22, 11, 4, 25};

  localparam logic [255:0] SB_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [31:0] desF(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  x;
    logic [31:0]  s;
    logic [31:0]  p;
    logic [5:0]   g;
    logic [5:0]   idx;
    logic [255:0] tab;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-E_TAB[j]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      g   = x[47-6*b -: 6];
      idx = {g[5], g[0], g[4:1]};
      tab = SB_TAB[b];
      s[31-4*b -: 4] = tab[255-4*idx -: 4];
    end
    for (int j = 0; j < 32; j++) p[31-j] = s[32-P_TAB[j]];
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_output: got f=0x%h tag=0x%h, expected no output", out_f, out_tag);
      end else begin
        e = sbQ.pop_front();
        checkOutput("out_f", 64'(out_f), 64'(e.f));
        checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
        popCycles.push_back(cycleCnt);
      end
    end
  end

  // Presents one operation and holds it until accepted; returns stall cycles.
  task automatic applyStimulus(input logic [31:0] r, input logic [47:0] k, input logic [3:0] tag,
                               input logic [31:0] expF, output int waits);
    exp_t e;
    in_valid = 1'b1;
    in_r     = r;
    in_k     = k;
    in_tag   = tag;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready) begin
      e.f   = expF;
      e.tag = tag;
      sbQ.push_back(e);
    end else begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waits);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          w;
    int          base;
    int          startCyc;
    int          n;
    logic [31:0] r [10];
    logic [47:0] k [10];

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_r = '0;
    in_k = '0;
    in_tag = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #3;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_f", 64'(out_f), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known vector: latency of two edges.
    out_ready = 1'b1;
    applyStimulus(32'hF0AAF0AA, 48'h1B02EFFC7072, 4'h3, 32'h234AA9BB, w);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("kv_not_yet_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("kv_out_valid", 64'(out_valid), 64'd1);
    checkOutput("kv_out_f", 64'(out_f), 64'h234AA9BB);
    checkOutput("kv_out_tag", 64'(out_tag), 64'h3);
    @(posedge clk);
    #1;
    idle(2);

    // Streaming with tags 0..7.
    for (int i = 0; i < 8; i++) begin
      r[i] = $urandom;
      k[i] = {16'($urandom), 32'($urandom)};
    end
    base = popCycles.size();
    startCyc = cycleCnt;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(r[i], k[i], 4'(i), desF(r[i], k[i]), w);
      checkOutput("stream_in_ready", 64'(w), 64'd0);
    end
    idle(4);
    checkOutput("stream_count", 64'(popCycles.size() - base), 64'd8);
    if (popCycles.size() >= base + 8) begin
      checkOutput("stream_latency", 64'(popCycles[base]), 64'(startCyc + 2));
      for (int i = 1; i < 8; i++)
        checkOutput("stream_consecutive", 64'(popCycles[base+i] - popCycles[base]), 64'(i));
    end

    // Backpressure: two entries fill, third is held off.
    for (int i = 0; i < 4; i++) begin
      r[i] = $urandom;
      k[i] = {16'($urandom), 32'($urandom)};
    end
    out_ready = 1'b0;
    applyStimulus(r[0], k[0], 4'h8, desF(r[0], k[0]), w);
    applyStimulus(r[1], k[1], 4'h9, desF(r[1], k[1]), w);
    checkOutput("bp_accepted", 64'(sbQ.size()), 64'd2);
    in_valid = 1'b1;
    in_r = r[2];
    in_k = k[2];
    in_tag = 4'hA;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_out_f_stable", 64'(out_f), 64'(desF(r[0], k[0])));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(r[2], k[2], 4'hA, desF(r[2], k[2]), w);
    checkOutput("bp_release_in_ready", 64'(w), 64'd0);
    applyStimulus(r[3], k[3], 4'hB, desF(r[3], k[3]), w);
    idle(4);
    checkOutput("bp_drained", 64'(sbQ.size()), 64'd0);

    // Flush with both stages full.
    out_ready = 1'b0;
    applyStimulus(r[0], k[0], 4'h1, desF(r[0], k[0]), w);
    applyStimulus(r[1], k[1], 4'h2, desF(r[1], k[1]), w);
    in_valid = 1'b1;
    in_r = r[2];
    in_k = k[2];
    in_tag = 4'h3;
    flush = 1'b1;
    @(negedge clk);
    sbQ.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);
    applyStimulus(r[3], k[3], 4'h4, desF(r[3], k[3]), w);
    idle(3);
    checkOutput("flush_next_emitted", 64'(sbQ.size()), 64'd0);

    // Flush while in_ready is high: stage-A entry and flush-cycle input vanish.
    applyStimulus(r[0], k[0], 4'h5, desF(r[0], k[0]), w);
    in_valid = 1'b1;
    in_r = r[1];
    in_k = k[1];
    in_tag = 4'h6;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush2_in_ready", 64'(in_ready), 64'd1);
    sbQ.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle(4);

    // Asynchronous reset while stage B holds valid data.
    out_ready = 1'b0;
    applyStimulus(r[2], k[2], 4'h7, desF(r[2], k[2]), w);
    applyStimulus(r[3], k[3], 4'h8, desF(r[3], k[3]), w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sbQ.delete();
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_out_f", 64'(out_f), 64'd0);
    checkOutput("rst_mid_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("rst_rel_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_rel_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(4);

    // Zero vector.
    applyStimulus(32'h0, 48'h0, 4'hC, 32'hD8D8DBBC, w);
    idle(3);

    n = 0;
    while (sbQ.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("final_queue_empty", 64'(sbQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
